game_state_handler: RTL



---
 rtl/game_state_if.sv | 30 +++
 rtl/game_state_handler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/game_state_if.sv
// Handshake bundle between the game logic layer and game_state_handler.
// Control strobes flow master->slave; score/health/status flow back.
interface game_state_if #(
    parameter int NUM_ENEMIES = 4,
    parameter int SCORE_W     = 8,
    parameter int HEALTH_W    = 4
);
    logic                   start_game;
    logic [NUM_ENEMIES-1:0] enemy_hit;
    logic                   player_hit;
    logic [SCORE_W-1:0]     current_score;
    logic [SCORE_W-1:0]     alltime_highscore;
    logic [HEALTH_W-1:0]    ship_health;
    logic [1:0]             game_state;
    logic                   gameover_pulse;
    logic                   new_record;
    logic                   invulnerable;

    modport master (
        output start_game, enemy_hit, player_hit,
        input  current_score, alltime_highscore, ship_health,
        input  game_state, gameover_pulse, new_record, invulnerable
    );

    modport slave (
        input  start_game, enemy_hit, player_hit,
        output current_score, alltime_highscore, ship_health,
        output game_state, gameover_pulse, new_record, invulnerable
    );
endinterface

// File: rtl/game_state_handler.sv
// Round FSM (idle/play/game over), saturating score, health with
// invulnerability window and highscore latch. Optional: LIVE_HIGHSCORE_EN.
module game_state_handler #(
    parameter int NUM_ENEMIES    = 4,
    parameter int SCORE_W        = 8,
    parameter int HEALTH_W       = 4,
    parameter int HEALTH_INIT    = 15,
    parameter int POINTS_PER_HIT = 1,
    parameter int INVULN_CYCLES  = 8
) (
    input  logic         clk,
    input  logic         reset,
    game_state_if.slave  gs
);
    localparam int SUM_W = SCORE_W + 4;
    localparam int CNT_W = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
    localparam logic [SUM_W-1:0] SCORE_MAX = {4'b0, {SCORE_W{1'b1}}};

`ifdef LIVE_HIGHSCORE_EN
    localparam bit LIVE_HS = 1'b1;
`else
    localparam bit LIVE_HS = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W-1:0]  hs_q, hs_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pulse_q, pulse_d;
    logic                rec_q, rec_d;
    logic                inv_q;
    logic [SUM_W-1:0]    hits;
    logic [SUM_W-1:0]    sum;
    logic                damage;

    // Next-state and datapath: one decision per state, holds by default
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        hs_d     = hs_q;
        health_d = health_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        rec_d    = rec_q;
        damage   = 1'b0;
        hits     = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            hits = hits + SUM_W'(gs.enemy_hit[i]);
        end
        sum = SUM_W'(score_q) + hits * SUM_W'(POINTS_PER_HIT);

        unique case (state_q)
            S_IDLE: begin
                if (gs.start_game) begin
                    state_d  = S_PLAY;
                    score_d  = '0;
                    health_d = HEALTH_W'(HEALTH_INIT);
                    cnt_d    = '0;
                    rec_d    = 1'b0;
                end
            end
            S_PLAY: begin
                score_d = (sum > SCORE_MAX) ? '1 : sum[SCORE_W-1:0];
                damage  = gs.player_hit && (cnt_q == '0);
                if (damage) begin
                    health_d = health_q - HEALTH_W'(1);
                    cnt_d    = CNT_W'(INVULN_CYCLES);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (LIVE_HS && (score_q > hs_q)) begin
                    hs_d  = score_q;
                    rec_d = 1'b1;
                end
                // Fatal hit: the immunity window is meaningless after the round
                if (damage && (health_q == HEALTH_W'(1))) begin
                    state_d = S_OVER;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_OVER: begin
                if (pulse_q && (score_q > hs_q)) begin
                    hs_d  = score_q;
                    rec_d = 1'b1;
                end
                if (gs.start_game) begin
                    state_d  = S_PLAY;
                    score_d  = '0;
                    health_d = HEALTH_W'(HEALTH_INIT);
                    cnt_d    = '0;
                    rec_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            score_q  <= '0;
            hs_q     <= '0;
            health_q <= HEALTH_W'(HEALTH_INIT);
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            rec_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            hs_q     <= hs_d;
            health_q <= health_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            rec_q    <= rec_d;
            inv_q    <= (cnt_d != '0);
        end
    end

    assign gs.current_score     = score_q;
    assign gs.alltime_highscore = hs_q;
    assign gs.ship_health       = health_q;
    assign gs.game_state        = state_q;
    assign gs.gameover_pulse    = pulse_q;
    assign gs.new_record        = rec_q;
    assign gs.invulnerable      = inv_q;
endmodule
